// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Inter-stage pipeline buffer with a valid/ready handshake and a 2-entry skid.
//   in_ready comes straight from the state register, so there is no
//   combinational path from out_ready back to in_ready. Full throughput is
//   kept by parking the beat accepted during a downstream stall in the skid
//   entry.
//
//   state | meaning
//   ------+------------------------------------------------
//   EMPTY | nothing held; out_valid=0, out_data=0
//   BUSY  | main entry valid, skid entry empty
//   FULL  | main and skid entries valid; in_ready=0
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset (highest priority)
//   flush      synchronous squash of all held entries
//   in_valid   upstream presents in_data
//   in_ready   stage can accept (registered)
//   in_data    upstream payload, W bits
//   out_valid  main entry holds a valid payload
//   out_ready  downstream accepts out_data this cycle
//   out_data   main entry payload, 0 while out_valid=0
//   occupancy  entries held (0..2)
module pipe_skid_stage #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   m_dat_q, m_dat_d;
   logic [W-1:0]   s_dat_q, s_dat_d;
   logic           m_v, s_v;
   logic           in_fire, out_fire;

   assign m_v       = (state_q != EMPTY);
   assign s_v       = (state_q == FULL);
   assign in_ready  = (state_q != FULL);
   assign out_valid = m_v;
   assign out_data  = m_dat_q;
   assign occupancy = {1'b0, m_v} + {1'b0, s_v};

   assign in_fire  = in_valid & in_ready;
   assign out_fire = m_v & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         m_dat_q <= '0;
         s_dat_q <= '0;
      end else begin
         state_q <= state_d;
         m_dat_q <= m_dat_d;
         s_dat_q <= s_dat_d;
      end
   end

   // in_data is only ever sampled under in_fire, so an undriven bus while
   // in_valid=0 cannot reach the storage.
   always_comb begin
      state_d = state_q;
      m_dat_d = m_dat_q;
      s_dat_d = s_dat_q;
      unique case (state_q)
         EMPTY: begin
            s_dat_d = '0;
            if (in_fire) begin
               state_d = BUSY;
               m_dat_d = in_data;
            end else begin
               m_dat_d = '0;
            end
         end
         BUSY: begin
            s_dat_d = '0;
            if (in_fire && out_fire) begin
               m_dat_d = in_data;
            end else if (in_fire) begin
               state_d = FULL;
               s_dat_d = in_data;
            end else if (out_fire) begin
               state_d = EMPTY;
               m_dat_d = '0;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_d = BUSY;
               m_dat_d = s_dat_q;
               s_dat_d = '0;
            end
         end
         default: begin
            state_d = EMPTY;
            m_dat_d = '0;
            s_dat_d = '0;
         end
      endcase

      // Squash wins over the handshake; the incoming beat belongs to the
      // squashed upstream and is dropped, an outgoing beat was already taken.
      if (flush) begin
         state_d = EMPTY;
         m_dat_d = '0;
         s_dat_d = '0;
      end
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   logic [W-1:0] mq[$];

   pipe_skid_stage #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an ordered list of at most two items.
   always @(posedge clk) begin
      bit ofire, ifire;
      if (rst || flush) begin
         mq.delete();
      end else begin
         ofire = (mq.size() > 0) && out_ready;
         ifire = in_valid && (mq.size() < 2);
         if (ofire) void'(mq.pop_front());
         if (ifire) mq.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
         check("m_out_data",  {16'b0, out_data},  (mq.size() > 0) ? {16'b0, mq[0]} : 32'd0);
         check("m_occupancy", {30'b0, occupancy}, mq.size());
         check("m_in_ready",  {31'b0, in_ready},  {31'b0, mq.size() < 2});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [W-1:0] d, input logic r,
                      input logic f, input logic rs);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      rst       = rs;
   endtask

   task automatic lit(input string tag, input logic v, input logic [W-1:0] d,
                      input logic [1:0] occ, input logic rdy);
      check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
      check({tag, "_data"},  {16'b0, out_data},  {16'b0, d});
      check({tag, "_occ"},   {30'b0, occupancy}, {30'b0, occ});
      check({tag, "_rdy"},   {31'b0, in_ready},  {31'b0, rdy});
   endtask

   initial begin
      // T1 reset with live input
      drv(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      tick();
      chk_en = 1'b1;
      tick();
      lit("t1_rst", 1'b0, 16'h0, 2'd0, 1'b1);
      drv(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick();
      lit("t1_rel", 1'b0, 16'h0, 2'd0, 1'b1);

      // T2 streaming
      for (int i = 1; i <= 8; i++) begin
         drv(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
         tick();
         lit("t2_str", 1'b1, W'(i), 2'd1, 1'b1);
      end
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      tick();
      lit("t2_end", 1'b0, 16'h0, 2'd0, 1'b1);

      // T3 stall / skid
      drv(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0);
      tick();
      lit("t3_a1", 1'b1, 16'h00A1, 2'd1, 1'b1);
      drv(1'b1, 16'h00A2, 1'b0, 1'b0, 1'b0);
      tick();
      lit("t3_full", 1'b1, 16'h00A1, 2'd2, 1'b0);
      drv(1'b1, 16'h00EE, 1'b0, 1'b0, 1'b0);
      tick();
      lit("t3_hold", 1'b1, 16'h00A1, 2'd2, 1'b0);
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      tick();
      lit("t3_a2", 1'b1, 16'h00A2, 2'd1, 1'b1);
      tick();
      lit("t3_drain", 1'b0, 16'h0, 2'd0, 1'b1);

      // T4 flush while full, with a coincident push
      drv(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 16'h00A2, 1'b0, 1'b0, 1'b0);
      tick();
      lit("t4_full", 1'b1, 16'h00A1, 2'd2, 1'b0);
      drv(1'b1, 16'h00B0, 1'b0, 1'b1, 1'b0);
      tick();
      lit("t4_flush", 1'b0, 16'h0, 2'd0, 1'b1);
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      tick();
      lit("t4_after", 1'b0, 16'h0, 2'd0, 1'b1);

      // T5 reset mid-operation
      drv(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
      tick();
      lit("t5_busy", 1'b1, 16'h1234, 2'd1, 1'b1);
      drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      tick();
      lit("t5_rst", 1'b0, 16'h0, 2'd0, 1'b1);
      drv(1'b1, 16'h5678, 1'b1, 1'b0, 1'b0);
      tick();
      lit("t5_new", 1'b1, 16'h5678, 2'd1, 1'b1);
      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      tick();
      lit("t5_end", 1'b0, 16'h0, 2'd0, 1'b1);

      // T6 random traffic against the reference
      for (int c = 0; c < 10000; c++) begin
         logic v;
         v         = 1'($urandom_range(0, 1));
         in_valid  = v;
         in_data   = v ? W'($urandom) : 'x;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 511) == 0);
         tick();
      end

      drv(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      lit("t6_end", 1'b0, 16'h0, 2'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
